// File: rtl/gc_pkg.sv
// Shared types and helpers for the garbled-circuit evaluator datapath.
// NR_AES is the AES-128 round count used by the fixed-key hash.
package gc_pkg;
  localparam int NR_AES = 10;

  typedef logic [127:0] label_t;
  typedef enum logic [1:0] {GT_AND = 2'd0, GT_XOR = 2'd1, GT_XNOR = 2'd2} gate_t;

  function automatic gate_t decode_gate(input logic [3:0] g_logic);
    gate_t gt;
    case (g_logic)
      4'b0110: gt = GT_XOR;
      4'b1001: gt = GT_XNOR;
      default: gt = GT_AND;
    endcase
    return gt;
  endfunction

  // {cid, gid, b} zero-extended; cid_z/gid_z arrive already zero-extended, s is their true width
  function automatic label_t make_tweak(input label_t cid_z, input label_t gid_z,
                                        input int unsigned s, input logic b);
    return (cid_z << (s + 32'd1)) | (gid_z << 1) | {127'd0, b};
  endfunction

  function automatic label_t hash_in(input label_t x, input label_t j);
    return {x[126:0], 1'b0} ^ j;
  endfunction
endpackage

// File: rtl/aes_round_stage.sv
// One registered AES-128 encryption round with a pass-through sideband.
// LAST=1 drops MixColumns for the final round.
module aes_round_stage #(
  parameter int PW   = 1,
  parameter bit LAST = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [127:0]  in_state,
  input  logic [127:0]  round_key,
  input  logic [PW-1:0] in_payload,
  output logic          out_valid,
  output logic [127:0]  out_state,
  output logic [PW-1:0] out_payload
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as a^254 (maps 0 to 0), followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] inv;
    t   = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] nxt;

  always_comb begin
    nxt = 128'd0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(in_state[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++) begin
      if (LAST) nxt[127-8*i -: 8] = sr[i] ^ round_key[127-8*i -: 8];
      else      nxt[127-8*i -: 8] = mc[i] ^ round_key[127-8*i -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    out_state   <= nxt;
    out_payload <= in_payload;
  end
endmodule

// File: rtl/gc_eval_engine.sv
// Half-gates evaluator: one gate per cycle, fixed-key AES hash (one round per stage), free-XOR.
// Optional AND-gate counter port enabled by defining GC_EVAL_COUNT_EN.
module gc_eval_engine
  import gc_pkg::*;
#(
  parameter int S = 20,
  parameter int K = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [128*(NR_AES+1)-1:0]   AES_expandedKey,
  input  logic [S-1:0]                cid,
  input  logic [S-1:0]                gid,
  input  logic                        in_valid,
  input  logic [3:0]                  g_logic,
  input  logic [K-1:0]                in0_label,
  input  logic [K-1:0]                in1_label,
  input  logic [K-1:0]                t0,
  input  logic [K-1:0]                t1,
  output logic                        out_valid,
  output logic [K-1:0]                out_label,
  output logic [S-1:0]                out_gid
`ifdef GC_EVAL_COUNT_EN
  ,
  output logic [31:0]                 and_count
`endif
);
  typedef struct packed {
    label_t         x0;
    label_t         wa;
    label_t         wb;
    label_t         t0;
    label_t         t1;
    logic [S-1:0]   gid;
    logic           is_xor;
    logic           is_xnor;
  } pay_t;

  gate_t  gt;
  label_t x0;
  label_t x1;

  always_comb begin
    gt = decode_gate(g_logic);
    x0 = hash_in(in0_label, make_tweak(label_t'(cid), label_t'(gid), S, 1'b0));
    x1 = hash_in(in1_label, make_tweak(label_t'(cid), label_t'(gid), S, 1'b1));
  end

  logic   s0_valid;
  label_t s0_st0;
  label_t s0_st1;
  pay_t   s0_pay;
  label_t s0_x1;

  always_ff @(posedge clk) begin
    if (rst) s0_valid <= 1'b0;
    else     s0_valid <= in_valid;
  end

  // Unhashed X values ride along so the final feed-forward H = AES(X) ^ X needs no recompute
  always_ff @(posedge clk) begin
    s0_st0 <= x0 ^ AES_expandedKey[127:0];
    s0_st1 <= x1 ^ AES_expandedKey[127:0];
    s0_pay <= {x0, in0_label, in1_label, t0, t1, gid, gt == GT_XOR, gt == GT_XNOR};
    s0_x1  <= x1;
  end

  logic   v0  [0:NR_AES];
  logic   v1  [0:NR_AES];
  label_t st0 [0:NR_AES];
  label_t st1 [0:NR_AES];
  pay_t   pay [0:NR_AES];
  label_t px1 [0:NR_AES];

  assign v0[0]  = s0_valid;
  assign v1[0]  = s0_valid;
  assign st0[0] = s0_st0;
  assign st1[0] = s0_st1;
  assign pay[0] = s0_pay;
  assign px1[0] = s0_x1;

  for (genvar r = 1; r <= NR_AES; r++) begin : g_round
    aes_round_stage #(.PW($bits(pay_t)), .LAST(r == NR_AES)) u_lane0 (
      .clk(clk), .rst(rst), .in_valid(v0[r-1]), .in_state(st0[r-1]),
      .round_key(AES_expandedKey[128*r +: 128]), .in_payload(pay[r-1]),
      .out_valid(v0[r]), .out_state(st0[r]), .out_payload(pay[r])
    );
    aes_round_stage #(.PW(128), .LAST(r == NR_AES)) u_lane1 (
      .clk(clk), .rst(rst), .in_valid(v1[r-1]), .in_state(st1[r-1]),
      .round_key(AES_expandedKey[128*r +: 128]), .in_payload(px1[r-1]),
      .out_valid(v1[r]), .out_state(st1[r]), .out_payload(px1[r])
    );
  end

  pay_t   fp;
  logic   f_valid;
  logic   f_xor_type;
  label_t h0;
  label_t h1;
  label_t wc;

  always_comb begin
    fp         = pay[NR_AES];
    f_valid    = v0[NR_AES] & v1[NR_AES];
    f_xor_type = fp.is_xor | fp.is_xnor;
    h0         = st0[NR_AES] ^ fp.x0;
    h1         = st1[NR_AES] ^ px1[NR_AES];
    wc         = 128'd0;
    if (f_xor_type) wc = fp.wa ^ fp.wb;
    else wc = (h0 ^ (fp.wa[0] ? fp.t0 : 128'd0)) ^ (h1 ^ (fp.wb[0] ? (fp.t1 ^ fp.wa) : 128'd0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_label <= '0;
      out_gid   <= '0;
    end else begin
      out_valid <= f_valid;
      if (f_valid) begin
        out_label <= wc;
        out_gid   <= fp.gid;
      end
    end
  end

`ifdef GC_EVAL_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                          and_count <= 32'd0;
    else if (f_valid && !f_xor_type) and_count <= and_count + 32'd1;
  end
`endif
endmodule
